// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage core.
// Tracks EX/MEM/WB destination tags, drives operand-forwarding selects and stalls.
module hazard_fwd_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  input  logic             mem_ready,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic             pipe_freeze,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt
);

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             rw;
    logic             mr;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             use1;
    logic             use2;
  } ex_tag_t;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             rw;
    logic             mr;
  } mem_tag_t;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             rw;
  } wb_tag_t;

  ex_tag_t  ex_q, ex_d;
  mem_tag_t mem_q, mem_d;
  wb_tag_t  wb_q, wb_d;

  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] mw_cnt_q, mw_cnt_d;

  logic mem_wait;
  logic load_use;
  logic mem_wr;
  logic wb_wr;
  logic kill_ex;

  assign mem_wait = mem_q.v & mem_q.mr & ~mem_ready;

  assign load_use = ex_q.v & ex_q.mr & (ex_q.rd != '0) & id_valid &
                    ((id_use_rs1 & (id_rs1 == ex_q.rd)) |
                     (id_use_rs2 & (id_rs2 == ex_q.rd)));

  assign mem_wr = mem_q.v & mem_q.rw & (mem_q.rd != '0);
  assign wb_wr  = wb_q.v & wb_q.rw & (wb_q.rd != '0);

  // Loads in MEM have no data yet; load-use stall keeps them off the mux.
  always_comb begin
    fwd_a_sel = 2'b00;
    if (ex_q.v & ex_q.use1) begin
      if (mem_wr & ~mem_q.mr & (mem_q.rd == ex_q.rs1)) begin
        fwd_a_sel = 2'b10;
      end else if (wb_wr & (wb_q.rd == ex_q.rs1)) begin
        fwd_a_sel = 2'b01;
      end
    end
  end

  always_comb begin
    fwd_b_sel = 2'b00;
    if (ex_q.v & ex_q.use2) begin
      if (mem_wr & ~mem_q.mr & (mem_q.rd == ex_q.rs2)) begin
        fwd_b_sel = 2'b10;
      end else if (wb_wr & (wb_q.rd == ex_q.rs2)) begin
        fwd_b_sel = 2'b01;
      end
    end
  end

  assign pipe_freeze = mem_wait;
  assign stall       = mem_wait | load_use;
  assign idex_bubble = ~mem_wait & (load_use | flush);
  assign kill_ex     = load_use | flush | ~id_valid;

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!mem_wait) begin
      wb_d  = '{v: mem_q.v, rd: mem_q.rd, rw: mem_q.rw};
      mem_d = '{v: ex_q.v, rd: ex_q.rd, rw: ex_q.rw, mr: ex_q.mr};
      if (kill_ex) begin
        ex_d = '0;
      end else begin
        ex_d = '{v: 1'b1, rd: id_rd, rw: id_reg_write,
                 mr: id_mem_read, rs1: id_rs1, rs2: id_rs2,
                 use1: id_use_rs1, use2: id_use_rs2};
      end
    end
  end

  always_comb begin
    lu_cnt_d = lu_cnt_q;
    mw_cnt_d = mw_cnt_q;
    if (!mem_wait && load_use && lu_cnt_q != '1) begin
      lu_cnt_d = lu_cnt_q + CNT_W'(1);
    end
    if (mem_wait && mw_cnt_q != '1) begin
      mw_cnt_d = mw_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      lu_cnt_q <= '0;
      mw_cnt_q <= '0;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      lu_cnt_q <= lu_cnt_d;
      mw_cnt_q <= mw_cnt_d;
    end
  end

  assign load_use_cnt = lu_cnt_q;
  assign mem_wait_cnt = mw_cnt_q;

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It tracks destination-register tags of in-flight instructions in EX, MEM and WB, and generates the select codes for the EX-stage operand-forwarding Mux2x1/Mux4x1 trees. It also generates load-use and memory-wait stalls and bubble insertion. It is the producer of every operand-mux `sel` in the datapath and sits beside the ID/EX pipeline register.

## Interface
Parameters:
- `REG_W`, 5, register index width
- `CNT_W`, 32, width of the performance counters

Ports:
- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `id_valid`  in  1  ID stage holds a real instruction
- `id_rs1`, `id_rs2`  in  REG_W  source registers decoded in ID
- `id_use_rs1`, `id_use_rs2`  in  1  instruction actually reads rs1 / rs2
- `id_rd`  in  REG_W  destination register
- `id_reg_write`  in  1  instruction writes `rd`
- `id_mem_read`  in  1  instruction is a load
- `flush`  in  1  branch or jump taken; kill the instruction entering EX
- `mem_ready`  in  1  data memory has completed the access in MEM
- `fwd_a_sel`, `fwd_b_sel`  out  2  EX operand select: 00 = register file, 01 = WB result, 10 = MEM ALU result
- `stall`  out  1  hold PC and IF/ID
- `pipe_freeze`  out  1  hold ID/EX, EX/MEM and MEM/WB
- `idex_bubble`  out  1  load a NOP into ID/EX this cycle
- `load_use_cnt`, `mem_wait_cnt`  out  CNT_W  saturating event counters

## Operation
- Internal tag registers:
  - EX = {v, rd, rw, mr, rs1, rs2, use1, use2}
  - MEM = {v, rd, rw, mr}
  - WB = {v, rd, rw}
- The `rw` bit of a tag counts only when `v` = 1 and `rd` ≠ 0. x0 never forwards and never causes a stall.
- `mem_wait` = MEM.v & MEM.mr & !`mem_ready`.
- `load_use` = EX.v & EX.mr & EX.rd ≠ 0 & id_valid & ((id_use_rs1 & id_rs1 == EX.rd) | (id_use_rs2 & id_rs2 == EX.rd)).
- Forwarding for operand A (operand B is identical using rs2/use2):
  - 10 if EX.use1, MEM matches EX.rs1 with rw set, and MEM.mr = 0.
  - Otherwise 01 if EX.use1 and WB matches EX.rs1 with rw set.
  - Otherwise 00.
  - MEM has priority over WB.
  - A load in MEM is never selected. The load-use stall guarantees this case cannot arise.
- Outputs, all combinational from the current tags and ID inputs:
  - `pipe_freeze` = `mem_wait`.
  - `stall` = `mem_wait` | `load_use`.
  - `idex_bubble` = !`mem_wait` & (`load_use` | `flush`).
- Tag update on each rising clk:
  - If `mem_wait`: all tags hold.
  - Otherwise: WB ← MEM, MEM ← EX.
  - EX ← invalid (v = 0) if `load_use` | `flush` | !id_valid; otherwise EX ← ID fields.
- `flush` during `mem_wait` is ignored. The branch unit holds `flush` until the cycle it is accepted.
- `flush` and `load_use` in the same cycle: a single bubble; `stall` is still asserted.
- Counters: `load_use_cnt` increments in each non-frozen cycle where `load_use` = 1; `mem_wait_cnt` increments in each cycle where `mem_wait` = 1. Both saturate at all-ones.

## Timing
- Reset (async assert, sync-safe deassert): all tag v bits = 0, counters = 0. This gives `fwd_*_sel` = 00 and `stall` = `pipe_freeze` = `idex_bubble` = 0 while reset is held, and immediately after it with `id_valid` = 0.
- Reset mid-stall clears all stalls on assertion with no further bubbles; the in-flight load is discarded.
- Forward selects are valid in the same cycle the consumer is in EX, with zero latency.
- Load-use stall lasts exactly 1 cycle when `mem_ready` = 1. The load then moves to WB, and the consumer enters EX with `fwd` = 01.
- `mem_wait` of N cycles freezes all tags for N cycles. No counter except `mem_wait_cnt` changes.
- Back-to-back dependent ALU ops: `fwd` = 10 the next cycle and 01 two cycles later, with no stall.

## Test plan
- add x5 then sub x6,x5,x1 in consecutive cycles -> `fwd_a_sel` = 10 on sub's EX cycle, `stall` = 0.
- add x5, nop, then or x7,x2,x5 -> `fwd_b_sel` = 01 on or's EX cycle. Writes to both MEM and WB matching x5 -> 10 wins.
- lw x8 then add x9,x8,x8 with `mem_ready` = 1 -> `stall` = `idex_bubble` = 1 for exactly 1 cycle, then `fwd_a_sel` = `fwd_b_sel` = 01, and `load_use_cnt` = 1.
- Instruction writing x0 followed by a reader of x0, and lw x0 followed by a use of x0 -> selects 00, no stall.
- lw in MEM with `mem_ready` low for 3 cycles -> `pipe_freeze` = `stall` = 1 for 3 cycles with tags unchanged, `mem_wait_cnt` = 3, and `flush` asserted during the wait is accepted only in the first non-frozen cycle.
- Assert `rst_n` = 0 during a load-use stall -> all outputs return to reset values immediately and the counters read 0.
